// File: rtl/diamond_pkg.sv
// rtl/diamond_pkg.sv - shared types, probe offsets, level layouts and popcount for the diamond tracker
package diamond_pkg;

  localparam int DEF_COORD_W      = 10;
  localparam int MAX_DIAMONDS     = 16;
  localparam int POP_W            = $clog2(MAX_DIAMONDS + 1);
  localparam int DEF_DIAMOND_SIZE = 20;
  localparam int DEF_PROBE_DX     = 8;
  localparam int DEF_PROBE_DY     = 4;

  typedef logic [DEF_COORD_W-1:0] coord_t;

  // Level 1 layouts; diamond 0 sits in the least significant slot.
  localparam logic [3*DEF_COORD_W-1:0] L1_BLUE_X = {10'd640, 10'd600, 10'd460};
  localparam logic [3*DEF_COORD_W-1:0] L1_BLUE_Y = {10'd300, 10'd300, 10'd408};
  localparam logic [3*DEF_COORD_W-1:0] L1_RED_X  = {10'd200, 10'd120, 10'd40};
  localparam logic [3*DEF_COORD_W-1:0] L1_RED_Y  = {10'd60,  10'd60,  10'd440};

  function automatic logic [POP_W-1:0] popcount(input logic [MAX_DIAMONDS-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_DIAMONDS; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/diamond_hit_detect.sv
// rtl/diamond_hit_detect.sv - combinational 8-probe sprite/diamond box test
module diamond_hit_detect
  import diamond_pkg::*;
#(
  parameter int COORD_W  = DEF_COORD_W,
  parameter int SIZE     = DEF_DIAMOND_SIZE,
  parameter int PROBE_DX = DEF_PROBE_DX,
  parameter int PROBE_DY = DEF_PROBE_DY
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [6:0]         width,
  input  logic [6:0]         height,
  input  logic [COORD_W-1:0] dx,
  input  logic [COORD_W-1:0] dy,
  output logic               hit
);

  // Two spare bits keep every probe sum exact, so off-screen probes stay off-screen.
  localparam int W = COORD_W + 2;
  localparam logic signed [W-1:0] S_SIZE = W'(SIZE);
  localparam logic signed [W-1:0] S_DX   = W'(PROBE_DX);
  localparam logic signed [W-1:0] S_DY   = W'(PROBE_DY);
  localparam logic signed [W-1:0] S_LIM  = W'(2 ** COORD_W);

  logic signed [W-1:0] xs, ys, half_w, half_h, left, right, top, bot, lo_x, lo_y;
  logic signed [W-1:0] px [8];
  logic signed [W-1:0] py [8];

  assign xs     = $signed(W'(x));
  assign ys     = $signed(W'(y));
  assign half_w = $signed(W'(width[6:1]));
  assign half_h = $signed(W'(height[6:1]));
  assign lo_x   = $signed(W'(dx));
  assign lo_y   = $signed(W'(dy));
  assign left   = xs - half_w;
  assign right  = xs + half_w;
  assign top    = ys - half_h;
  assign bot    = ys + half_h;

  assign px[0] = xs;         assign py[0] = top;
  assign px[1] = xs;         assign py[1] = bot;
  assign px[2] = left;       assign py[2] = ys;
  assign px[3] = right;      assign py[3] = ys;
  assign px[4] = xs - S_DX;  assign py[4] = bot - S_DY;
  assign px[5] = xs + S_DX;  assign py[5] = bot + S_DY;
  assign px[6] = xs - S_DX;  assign py[6] = top - S_DY;
  assign px[7] = xs + S_DX;  assign py[7] = top + S_DY;

  function automatic logic in_span(input logic signed [W-1:0] p, input logic signed [W-1:0] lo);
    return (p >= lo) && (p < lo + S_SIZE) && (p < S_LIM);
  endfunction

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (in_span(px[i], lo_x) && in_span(py[i], lo_y)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/diamond_collect_tracker.sv
// rtl/diamond_collect_tracker.sv - sticky per-diamond eaten flags, eat pulses and collected count
module diamond_collect_tracker
  import diamond_pkg::*;
#(
  parameter int NUM_DIAMONDS = 3,
  parameter int COORD_W      = DEF_COORD_W,
  parameter int DIAMOND_SIZE = DEF_DIAMOND_SIZE,
  parameter int PROBE_DX     = DEF_PROBE_DX,
  parameter int PROBE_DY     = DEF_PROBE_DY,
  parameter int CNT_W        = $clog2(NUM_DIAMONDS + 1)
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            sample_en,
  input  logic                            level_clear,
  input  logic [COORD_W-1:0]              x,
  input  logic [COORD_W-1:0]              y,
  input  logic [6:0]                      width,
  input  logic [6:0]                      height,
  input  logic [NUM_DIAMONDS*COORD_W-1:0] diamond_x,
  input  logic [NUM_DIAMONDS*COORD_W-1:0] diamond_y,
  output logic [NUM_DIAMONDS-1:0]         eaten,
  output logic [NUM_DIAMONDS-1:0]         eat_pulse,
  output logic [CNT_W-1:0]                collected_cnt,
  output logic                            all_collected
);

  logic [NUM_DIAMONDS-1:0] hit, new_eat, eaten_d;
  logic [MAX_DIAMONDS-1:0] eaten_wide;
  logic [CNT_W-1:0]        cnt_d;

  for (genvar i = 0; i < NUM_DIAMONDS; i++) begin : g_det
    diamond_hit_detect #(
      .COORD_W  (COORD_W),
      .SIZE     (DIAMOND_SIZE),
      .PROBE_DX (PROBE_DX),
      .PROBE_DY (PROBE_DY)
    ) u_det (
      .x      (x),
      .y      (y),
      .width  (width),
      .height (height),
      .dx     (diamond_x[i*COORD_W +: COORD_W]),
      .dy     (diamond_y[i*COORD_W +: COORD_W]),
      .hit    (hit[i])
    );
  end

  // Count is taken from the next eaten vector so it lands on the same edge, never a cycle late.
  always_comb begin
    new_eat = '0;
    eaten_d = eaten;
    if (level_clear) begin
      eaten_d = '0;
    end else if (sample_en) begin
      new_eat = hit & ~eaten;
      eaten_d = eaten | new_eat;
    end
    eaten_wide = '0;
    eaten_wide[NUM_DIAMONDS-1:0] = eaten_d;
    cnt_d = CNT_W'(popcount(eaten_wide));
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      eaten         <= '0;
      eat_pulse     <= '0;
      collected_cnt <= '0;
      all_collected <= 1'b0;
    end else begin
      eaten         <= eaten_d;
      eat_pulse     <= new_eat;
      collected_cnt <= cnt_d;
      all_collected <= (cnt_d == CNT_W'(NUM_DIAMONDS));
    end
  end

endmodule

// File: tb/tb_diamond_collect_tracker.sv
// tb/tb_diamond_collect_tracker.sv - scoreboard bench for diamond_collect_tracker
module tb_diamond_collect_tracker;
  import diamond_pkg::*;

  typedef struct {
    logic [8:0] v;  // {eaten, eat_pulse, collected_cnt, all_collected}
    string      tag;
  } exp_t;

  logic        Clk, Reset, sample_en, level_clear;
  coord_t      x, y;
  logic [6:0]  width, height;
  logic [29:0] diamond_x, diamond_y;
  logic [2:0]  eaten, eat_pulse;
  logic [1:0]  collected_cnt;
  logic        all_collected;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  diamond_collect_tracker #(.NUM_DIAMONDS(3)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .sample_en     (sample_en),
    .level_clear   (level_clear),
    .x             (x),
    .y             (y),
    .width         (width),
    .height        (height),
    .diamond_x     (diamond_x),
    .diamond_y     (diamond_y),
    .eaten         (eaten),
    .eat_pulse     (eat_pulse),
    .collected_cnt (collected_cnt),
    .all_collected (all_collected)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic cmp(input string tag, input logic [8:0] act, input logic [8:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got eaten=%b pulse=%b cnt=%0d all=%b, required eaten=%b pulse=%b cnt=%0d all=%b",
               tag, act[8:6], act[5:3], act[2:1], act[0], req[8:6], req[5:3], req[2:1], req[0]);
    end
  endtask

  // Monitor: every negedge the DUT presents its state for the most recently issued cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.tag, {eaten, eat_pulse, collected_cnt, all_collected}, e.v);
      end
    end
  end

  task automatic step(input string tag, input int sx, input int sy, input int sw, input int sh,
                      input logic se, input logic lc,
                      input logic [2:0] e_eat, input logic [2:0] e_pul, input logic [1:0] e_cnt,
                      input logic e_all);
    exp_t e;
    @(negedge Clk);
    #1;
    x = coord_t'(sx); y = coord_t'(sy);
    width = 7'(sw); height = 7'(sh);
    sample_en = se; level_clear = lc;
    e.v = {e_eat, e_pul, e_cnt, e_all};
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  initial begin
    Reset = 1'b1; sample_en = 1'b0; level_clear = 1'b0;
    x = 10'd100; y = 10'd100; width = 7'd16; height = 7'd16;
    diamond_x = L1_BLUE_X; diamond_y = L1_BLUE_Y;
    #2 Reset = 1'b0;
    #1 cmp("reset_initial", {eaten, eat_pulse, collected_cnt, all_collected}, 9'b0);
    @(negedge Clk); #1 Reset = 1'b1;

    // d0=(460,408) d1=(600,300) d2=(640,300)
    step("idle",        100, 100, 16, 16, 1, 0, 3'b000, 3'b000, 2'd0, 0);
    step("eat_d0",      470, 420, 16, 16, 1, 0, 3'b001, 3'b001, 2'd1, 0);
    step("d0_pulse_end",100, 100, 16, 16, 1, 0, 3'b001, 3'b000, 2'd1, 0);
    for (int i = 0; i < 10; i++)
      step("d0_held",   470, 420, 16, 16, 1, 0, 3'b001, 3'b000, 2'd1, 0);
    step("no_sample_a", 630, 310, 40, 16, 0, 0, 3'b001, 3'b000, 2'd1, 0);
    step("no_sample_b", 630, 310, 40, 16, 0, 0, 3'b001, 3'b000, 2'd1, 0);
    step("eat_d1_d2",   630, 310, 40, 16, 1, 0, 3'b111, 3'b110, 2'd3, 1);
    step("all_hold",    630, 310, 40, 16, 1, 0, 3'b111, 3'b000, 2'd3, 1);
    step("clear",       100, 100, 16, 16, 0, 1, 3'b000, 3'b000, 2'd0, 0);
    step("clear_vs_hit",470, 420, 16, 16, 1, 1, 3'b000, 3'b000, 2'd0, 0);
    step("after_clear", 470, 420, 16, 16, 1, 0, 3'b001, 3'b001, 2'd1, 0);
    step("eat_d2",      650, 310, 16, 16, 1, 0, 3'b101, 3'b100, 2'd2, 0);

    // Asynchronous reset mid-cycle with eaten=101.
    @(negedge Clk); #2;
    sample_en = 1'b0;
    Reset = 1'b0;
    #1 cmp("async_reset", {eaten, eat_pulse, collected_cnt, all_collected}, 9'b0);
    @(negedge Clk); #1 Reset = 1'b1;

    // Diamond 0 moved to the right screen edge; left probe at -5 must not wrap to 1019.
    diamond_x[9:0] = 10'd1004; diamond_y[9:0] = 10'd0;
    step("wrap_guard_a",  3, 10, 16, 16, 1, 0, 3'b000, 3'b000, 2'd0, 0);
    step("wrap_guard_b",  3, 10, 16, 16, 1, 0, 3'b000, 3'b000, 2'd0, 0);
    step("edge_eat_d0", 1010, 10, 16, 16, 1, 0, 3'b001, 3'b001, 2'd1, 0);
    step("edge_hold",   1010, 10, 16, 16, 1, 0, 3'b001, 3'b000, 2'd1, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge Clk);
    @(negedge Clk); #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
